// File: rtl/stack_sequencer_if.sv
// CPU-side request/response bundle for stack_sequencer.
// master = CPU (issues requests), slave = sequencer (accepts and responds).
interface stack_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             i_req_valid;
  logic             o_req_ready;
  logic [2:0]       i_req_op;
  logic [WIDTH-1:0] i_req_data;
  logic             o_rsp_valid;
  logic [1:0]       o_rsp_err;
  logic [WIDTH-1:0] o_rsp_A;
  logic [WIDTH-1:0] o_rsp_B;

  modport master (
    output i_req_valid, i_req_op, i_req_data,
    input  o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_A, o_rsp_B
  );

  modport slave (
    input  i_req_valid, i_req_op, i_req_data,
    output o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_A, o_rsp_B
  );
endinterface

// File: rtl/stack_sequencer.sv
// Depth-checking front end for the hardware data stack: one op at a time, fetch then store.
// Optional STACK_SEQ_HIGHWATER_EN adds o_high_water (max depth seen since reset).
module stack_sequencer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  stack_sequencer_if.slave       cpu,
  output logic [$clog2(DEPTH):0] o_depth,
`ifdef STACK_SEQ_HIGHWATER_EN
  output logic [$clog2(DEPTH):0] o_high_water,
`endif
  output logic                   o_stk_fetch,
  output logic                   o_stk_store,
  output logic [2:0]             o_stk_function,
  output logic [WIDTH-1:0]       o_stk_write_D,
  input  logic [WIDTH-1:0]       i_stk_read_A,
  input  logic [WIDTH-1:0]       i_stk_read_B
);
  localparam int DW = $clog2(DEPTH) + 1;
  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  typedef enum logic [2:0] {
    OP_PUSH   = 3'b000,
    OP_D1PUSH = 3'b001,
    OP_D2PUSH = 3'b010,
    OP_SWAP   = 3'b011,
    OP_DROP   = 3'b100,
    OP_DROP2  = 3'b101,
    OP_ROLL   = 3'b110,
    OP_PEEK   = 3'b111
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_STORE, S_CAPTURE, S_RSP
  } state_t;

  state_t           state_q, state_d;
  logic             ready_q;
  op_t              func_q;
  logic [WIDTH-1:0] data_q;
  logic [1:0]       err_q, err_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic [WIDTH-1:0] rsp_a_q, rsp_b_q;
  logic             accept;

  // Error code for an op given the current depth: bit0 underflow, bit1 overflow.
  function automatic logic [1:0] depth_check(input op_t op, input logic [DW-1:0] d);
    logic [1:0] e;
    e = 2'b00;
    case (op)
      OP_PUSH:                       e = (d == FULL)     ? 2'b10 : 2'b00;
      OP_D1PUSH, OP_DROP:            e = (d < DW'(1))    ? 2'b01 : 2'b00;
      OP_D2PUSH, OP_SWAP, OP_DROP2:  e = (d < DW'(2))    ? 2'b01 : 2'b00;
      OP_ROLL:                       e = (d < DW'(3))    ? 2'b01 : 2'b00;
      default:                       e = 2'b00;
    endcase
    return e;
  endfunction

  assign accept = cpu.i_req_valid && ready_q;

  // NOTE: every variable is given a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    depth_d = depth_q;
    case (state_q)
      S_IDLE: if (accept) begin
        err_d   = depth_check(op_t'(cpu.i_req_op), depth_q);
        state_d = (err_d != 2'b00) ? S_RSP : S_FETCH;
      end
      S_FETCH: state_d = S_STORE;
      S_STORE: begin
        state_d = (func_q == OP_PEEK) ? S_CAPTURE : S_RSP;
        case (func_q)
          OP_PUSH:            depth_d = depth_q + DW'(1);
          OP_D2PUSH, OP_DROP: depth_d = depth_q - DW'(1);
          OP_DROP2:           depth_d = depth_q - DW'(2);
          default:            depth_d = depth_q;
        endcase
      end
      S_CAPTURE: state_d = S_RSP;
      S_RSP:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // NOTE: ready is a register so it stays 0 throughout reset and rises one cycle after release.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      func_q  <= OP_PUSH;
      data_q  <= '0;
      err_q   <= 2'b00;
      depth_q <= '0;
      rsp_a_q <= '0;
      rsp_b_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == S_IDLE);
      err_q   <= err_d;
      depth_q <= depth_d;
      if (accept) begin
        func_q <= op_t'(cpu.i_req_op);
        data_q <= cpu.i_req_data;
      end
      if (state_q == S_CAPTURE) begin
        rsp_a_q <= i_stk_read_A;
        rsp_b_q <= i_stk_read_B;
      end
    end
  end

`ifdef STACK_SEQ_HIGHWATER_EN
  logic [DW-1:0] hw_q;
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)              hw_q <= '0;
    else if (depth_d > hw_q) hw_q <= depth_d;
  end
  assign o_high_water = hw_q;
`endif

  assign cpu.o_req_ready = ready_q;
  assign cpu.o_rsp_valid = (state_q == S_RSP);
  assign cpu.o_rsp_err   = (state_q == S_RSP) ? err_q : 2'b00;
  assign cpu.o_rsp_A     = rsp_a_q;
  assign cpu.o_rsp_B     = rsp_b_q;
  assign o_depth         = depth_q;
  assign o_stk_fetch     = (state_q == S_FETCH);
  assign o_stk_store     = (state_q == S_STORE);
  assign o_stk_function  = func_q;
  assign o_stk_write_D   = data_q;
endmodule

// File: tb/tb_stack_sequencer.sv
// Scoreboard bench for stack_sequencer: behavioural stack on the strobe side,
// reference stack model queues expected responses at request acceptance.
module tb_stack_sequencer;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int DW    = $clog2(DEPTH) + 1;
  localparam logic [WIDTH-1:0] EMPTY = 16'hDEAD;

  localparam logic [2:0] PUSH = 3'b000, D1PUSH = 3'b001, D2PUSH = 3'b010, SWAP = 3'b011,
                         DROP = 3'b100, DROP2  = 3'b101, ROLL   = 3'b110, PEEK = 3'b111;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  always #5 i_clk = ~i_clk;

  stack_sequencer_if #(.WIDTH(WIDTH)) cpu ();
  logic [DW-1:0]    o_depth;
`ifdef STACK_SEQ_HIGHWATER_EN
  logic [DW-1:0]    o_high_water;
`endif
  logic             o_stk_fetch, o_stk_store;
  logic [2:0]       o_stk_function;
  logic [WIDTH-1:0] o_stk_write_D, i_stk_read_A, i_stk_read_B;

  stack_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .cpu            (cpu),
    .o_depth        (o_depth),
`ifdef STACK_SEQ_HIGHWATER_EN
    .o_high_water   (o_high_water),
`endif
    .o_stk_fetch    (o_stk_fetch),
    .o_stk_store    (o_stk_store),
    .o_stk_function (o_stk_function),
    .o_stk_write_D  (o_stk_write_D),
    .i_stk_read_A   (i_stk_read_A),
    .i_stk_read_B   (i_stk_read_B)
  );

  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] data;
    logic [1:0]       err;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    int               depth;
    int               hw;
    int               acc;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] ref_stk[$];   // index 0 is top of stack
  int               ref_hw = 0;
  int               cyc = 0;
  int               n_tests = 0;
  int               n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge i_clk) cyc <= cyc + 1;

  // Behavioural hardware stack driven by the store strobe.
  logic [WIDTH-1:0] mem [DEPTH];
  int sp;
  always @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) sp <= 0;
    else if (o_stk_store) begin
      case (o_stk_function)
        PUSH:   if (sp < DEPTH) begin mem[sp] <= o_stk_write_D; sp <= sp + 1; end
        D1PUSH: if (sp >= 1) mem[sp-1] <= o_stk_write_D;
        D2PUSH: if (sp >= 2) begin mem[sp-2] <= o_stk_write_D; sp <= sp - 1; end
        SWAP:   if (sp >= 2) begin mem[sp-1] <= mem[sp-2]; mem[sp-2] <= mem[sp-1]; end
        DROP:   if (sp >= 1) sp <= sp - 1;
        DROP2:  if (sp >= 2) sp <= sp - 2;
        ROLL:   if (sp >= 3) begin
          mem[sp-1] <= mem[sp-2];
          mem[sp-2] <= mem[sp-3];
          mem[sp-3] <= mem[sp-1];
        end
        default: ;
      endcase
    end
  end
  assign i_stk_read_A = (sp > 0) ? mem[sp-1] : EMPTY;
  assign i_stk_read_B = (sp > 1) ? mem[sp-2] : EMPTY;

  // Response monitor: sampled on the falling edge, away from the active edge.
  int               n_fetch = 0, n_store = 0;
  logic [2:0]       st_func;
  logic [WIDTH-1:0] st_data;
  exp_t             mon_e;
  int               lat;
  always @(negedge i_clk) begin
    if (!i_rst) begin
      n_fetch = 0;
      n_store = 0;
    end else begin
      if (o_stk_fetch || o_stk_store) check("strobe_overlap", o_stk_fetch & o_stk_store, 0);
      if (o_stk_fetch) n_fetch++;
      if (o_stk_store) begin
        n_store++;
        st_func = o_stk_function;
        st_data = o_stk_write_D;
      end
      if (cpu.o_rsp_valid) begin
        check("rsp_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          lat = (mon_e.err != 2'b00) ? 1 : ((mon_e.op == PEEK) ? 4 : 3);
          check("latency", cyc - mon_e.acc, lat);
          check("rsp_err", cpu.o_rsp_err, mon_e.err);
          check("depth", o_depth, mon_e.depth);
          check("fetch_cnt", n_fetch, (mon_e.err == 2'b00) ? 1 : 0);
          check("store_cnt", n_store, (mon_e.err == 2'b00) ? 1 : 0);
          if (mon_e.err == 2'b00) begin
            check("store_func", st_func, mon_e.op);
            check("store_data", st_data, mon_e.data);
          end
          if (mon_e.op == PEEK) begin
            check("peek_A", cpu.o_rsp_A, mon_e.a);
            check("peek_B", cpu.o_rsp_B, mon_e.b);
          end
`ifdef STACK_SEQ_HIGHWATER_EN
          check("high_water", o_high_water, mon_e.hw);
`endif
        end
        n_fetch = 0;
        n_store = 0;
      end
    end
  end

  // Issues one request (called just after a falling edge) and queues its expected response.
  task automatic do_op(input logic [2:0] op, input logic [WIDTH-1:0] data);
    int   n = 0;
    int   need;
    exp_t e;
    logic [WIDTH-1:0] t;
    cpu.i_req_valid = 1'b1;
    cpu.i_req_op    = op;
    cpu.i_req_data  = data;
    while (!cpu.o_req_ready && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    if (!cpu.o_req_ready) begin
      check("ready_timeout", cpu.o_req_ready, 1);
      cpu.i_req_valid = 1'b0;
      return;
    end
    case (op)
      D1PUSH, DROP:        need = 1;
      D2PUSH, SWAP, DROP2: need = 2;
      ROLL:                need = 3;
      default:             need = 0;
    endcase
    e.op = op; e.data = data; e.acc = cyc; e.a = '0; e.b = '0;
    if (op == PUSH && ref_stk.size() == DEPTH) e.err = 2'b10;
    else if (ref_stk.size() < need)            e.err = 2'b01;
    else                                       e.err = 2'b00;
    if (e.err == 2'b00) begin
      case (op)
        PUSH:   ref_stk.push_front(data);
        D1PUSH: ref_stk[0] = data;
        D2PUSH: begin void'(ref_stk.pop_front()); ref_stk[0] = data; end
        SWAP:   begin t = ref_stk[0]; ref_stk[0] = ref_stk[1]; ref_stk[1] = t; end
        DROP:   void'(ref_stk.pop_front());
        DROP2:  begin void'(ref_stk.pop_front()); void'(ref_stk.pop_front()); end
        ROLL:   begin
          t = ref_stk[0]; ref_stk[0] = ref_stk[1]; ref_stk[1] = ref_stk[2]; ref_stk[2] = t;
        end
        default: begin
          e.a = (ref_stk.size() > 0) ? ref_stk[0] : EMPTY;
          e.b = (ref_stk.size() > 1) ? ref_stk[1] : EMPTY;
        end
      endcase
    end
    e.depth = ref_stk.size();
    if (e.depth > ref_hw) ref_hw = e.depth;
    e.hw = ref_hw;
    sb.push_back(e);
    @(negedge i_clk);
    cpu.i_req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  task automatic check_quiet(input string phase);
    check({phase, "_ready"}, cpu.o_req_ready, 0);
    check({phase, "_rsp_valid"}, cpu.o_rsp_valid, 0);
    check({phase, "_rsp_err"}, cpu.o_rsp_err, 0);
    check({phase, "_depth"}, o_depth, 0);
    check({phase, "_fetch"}, o_stk_fetch, 0);
    check({phase, "_store"}, o_stk_store, 0);
    check({phase, "_function"}, o_stk_function, 0);
    check({phase, "_write_D"}, o_stk_write_D, 0);
    check({phase, "_rsp_A"}, cpu.o_rsp_A, 0);
    check({phase, "_rsp_B"}, cpu.o_rsp_B, 0);
`ifdef STACK_SEQ_HIGHWATER_EN
    check({phase, "_high_water"}, o_high_water, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cpu.i_req_valid = 1'b0;
    cpu.i_req_op    = 3'b000;
    cpu.i_req_data  = '0;
    #2;
    check_quiet("reset");
    @(negedge i_clk);
    check("reset_ready_held", cpu.o_req_ready, 0);
    i_rst = 1'b1;
    @(negedge i_clk);
    check("ready_after_reset", cpu.o_req_ready, 1);

    do_op(PUSH, 16'h1111);
    drain();
    do_op(DROP, 16'h0);
    do_op(DROP, 16'h0);               // underflow on empty stack
    do_op(PEEK, 16'h0);               // empty PEEK is legal
    do_op(PUSH, 16'hAAAA);
    do_op(PUSH, 16'hBBBB);
    do_op(SWAP, 16'h0);
    do_op(PEEK, 16'h0);
    do_op(DROP2, 16'h0);
    for (int i = 1; i <= 3; i++) do_op(PUSH, 16'(i));
    do_op(ROLL, 16'h0);
    do_op(PEEK, 16'h0);
    do_op(DROP2, 16'h0);
    do_op(DROP, 16'h0);
    for (int i = 0; i < DEPTH; i++) do_op(PUSH, 16'h1000 + 16'(i));
    do_op(PUSH, 16'h9999);            // overflow at full depth
    do_op(D1PUSH, 16'h7777);
    do_op(D2PUSH, 16'h8888);
    do_op(PEEK, 16'h0);
    for (int i = 0; i < 3; i++) do_op(DROP2, 16'h0);
    do_op(DROP, 16'h0);
    do_op(PUSH, 16'h4242);
    do_op(D2PUSH, 16'h1234);          // needs two entries
    do_op(ROLL, 16'h0);
    do_op(SWAP, 16'h0);
    do_op(DROP2, 16'h0);
    do_op(D1PUSH, 16'h5151);
    do_op(PEEK, 16'h0);
    do_op(DROP, 16'h0);
    drain();

    // Reset during STORE aborts the op with no response.
    do_op(PUSH, 16'h5555);
    @(negedge i_clk);
    check("store_before_reset", o_stk_store, 1);
    i_rst = 1'b0;
    #1;
    check_quiet("abort");
    sb.delete();
    ref_stk.delete();
    ref_hw = 0;
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    check("ready_after_abort", cpu.o_req_ready, 1);
    check("depth_after_abort", o_depth, 0);
    repeat (6) @(negedge i_clk);

    do_op(PUSH, 16'h6666);
    do_op(PEEK, 16'h0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/stack_sequencer.md
Name: stack_sequencer

Overview:
- Front-end controller directly upstream of the CPU's hardware data stack (3-bit function code, fetch/store strobes).
- Accepts one stack operation at a time from the CPU over a valid/ready handshake, checks depth, and drives the stack's fetch-then-store two-cycle protocol.
- Shadows the stack depth, blocks illegal operations with overflow/underflow errors, and returns PEEK results as a one-cycle response.

Parameters:
- WIDTH, 16, data word width; must match the stack.
- DEPTH, 8, stack capacity in entries; must match the stack.

Ports:
- i_clk  in  1  system clock; all state on rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_req_valid  in  1  CPU operation request.
- o_req_ready  out  1  sequencer can accept a request.
- i_req_op  in  3  function: 000 PUSH, 001 D1PUSH, 010 D2PUSH, 011 SWAP, 100 DROP, 101 DROP2, 110 ROLL, 111 PEEK.
- i_req_data  in  WIDTH  write data for PUSH/D1PUSH/D2PUSH.
- o_rsp_valid  out  1  one-cycle completion pulse.
- o_rsp_err  out  2  bit0 underflow, bit1 overflow; valid with o_rsp_valid.
- o_rsp_A  out  WIDTH  top of stack (PEEK only).
- o_rsp_B  out  WIDTH  second entry (PEEK only).
- o_depth  out  clog2(DEPTH)+1  current shadow depth, 0..DEPTH.
- o_stk_fetch  out  1  stack fetch strobe.
- o_stk_store  out  1  stack store strobe.
- o_stk_function  out  3  function code to the stack.
- o_stk_write_D  out  WIDTH  write data to the stack.
- i_stk_read_A  in  WIDTH  stack read port A (registered in the stack).
- i_stk_read_B  in  WIDTH  stack read port B.

Behaviour:
- Reset (i_rst low, asynchronous): state IDLE, depth 0, all outputs 0, including o_req_ready. Reset mid-operation aborts with no response. The stack is reset on the same reset net.
- States: IDLE, FETCH, STORE, CAPTURE, RSP.
- o_req_ready = 1 only in IDLE. A request is accepted on a cycle with valid&ready. op and data are latched into o_stk_function/o_stk_write_D and held until return to IDLE.
- Minimum depth for each op: PUSH needs depth<DEPTH; D1PUSH 1; D2PUSH 2; SWAP 2; DROP 1; DROP2 2; ROLL 3; PEEK 0.
- Check failed at acceptance (cycle N):
  - Go directly to RSP; no fetch or store strobe; depth unchanged.
  - RSP at N+1 with err=01 (underflow) or 10 (overflow).
- Check passed, accepted at cycle N:
  - N+1 FETCH: o_stk_fetch=1.
  - N+2 STORE: o_stk_store=1; depth updated at the end of this cycle: PUSH +1, D2PUSH -1, DROP -1, DROP2 -2, others unchanged.
  - Non-PEEK: RSP at N+3, err=00.
  - PEEK: N+3 CAPTURE registers i_stk_read_A/B into o_rsp_A/B; RSP at N+4.
- Strobes are exactly one cycle each and never overlap.
- RSP lasts one cycle with o_rsp_valid=1, then IDLE. There is no response backpressure. o_rsp_A/B hold their last PEEK value otherwise.
- Back-to-back: the next request can be accepted in the IDLE cycle after RSP. Throughput is 1 op per 4 cycles (5 for PEEK).
- i_req_valid while busy is ignored (ready=0). The requester holds its request until accepted.
- PEEK on an empty stack is legal; it returns whatever the stack presents (its empty marker), err=00.

Optional Feature:
- STACK_SEQ_HIGHWATER_EN defined: adds output port o_high_water [clog2(DEPTH)+1]. It holds the maximum depth seen since reset, updates in the same cycle as depth, and resets to 0.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, PUSH 0x1111 -> fetch strobe at N+1, store at N+2 with function 000 and data 0x1111, rsp_valid at N+3 err=00, depth=1.
- PUSH 0xAAAA, PUSH 0xBBBB, SWAP, PEEK -> PEEK rsp at N+4 with A=0xAAAA, B=0xBBBB; depth=2.
- Empty stack: DROP -> rsp at N+1 err=01, no fetch/store strobes, depth stays 0.
- 8 PUSHes then a 9th PUSH 0x9999 -> 9th rsp err=10, no store, depth=8.
- PUSH 1,2,3, ROLL, PEEK -> A=0x0002, B=0x0001; then DROP2 -> depth=1.
- Assert i_rst low during STORE of a PUSH -> all outputs 0 immediately, depth=0, no rsp_valid; after release, ready=1 next cycle.
